ocra1_dac_spi: RTL

OCRA1_DAC_SPI -- requirements
Module: ocra1_dac_spi

---
 rtl/ocra_grad_pkg.sv | 16 +
 rtl/ocra1_sclk_div.sv | 39 +++
 rtl/ocra1_dac_spi.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ocra_grad_pkg.sv
// Shared constants and state encoding for the OCRA1 gradient DAC serial link.
package ocra_grad_pkg;

  localparam int unsigned DacWidth = 24;
  localparam int unsigned NumCh    = 4;
  localparam int unsigned BitCntW  = 5;
  localparam int unsigned PhaseW   = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StGap   = 2'd2,
    StLdac  = 2'd3
  } dac_state_e;

endpackage

// File: rtl/ocra1_sclk_div.sv
// Half-period divider: tick_o marks the last clk cycle of each SCLK half-period.
module ocra1_sclk_div
  import ocra_grad_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [PhaseW-1:0] LastPhase = PhaseW'(SCLK_DIV - 1);

  logic [PhaseW-1:0] phase_q, phase_d;

  assign tick_o = en_i && !restart_i && (phase_q == LastPhase);

  // Count 0..SCLK_DIV-1; restart realigns the phase to a new frame.
  always_comb begin
    phase_d = phase_q;
    if (restart_i) begin
      phase_d = '0;
    end else if (en_i) begin
      phase_d = tick_o ? '0 : phase_q + PhaseW'(1);
    end
  end

  // Phase register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/ocra1_dac_spi.sv
// Four-channel DAC serialiser: shared SCLK/SYNCn/LDACn, one data line per channel.
module ocra1_dac_spi
  import ocra_grad_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 2,
  parameter int unsigned LDAC_EN  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DacWidth-1:0] dac0_i,
  input  logic [DacWidth-1:0] dac1_i,
  input  logic [DacWidth-1:0] dac2_i,
  input  logic [DacWidth-1:0] dac3_i,
  input  logic                valid_i,
  input  logic                clear_i,
  output logic                busy_o,
  output logic                overflow_o,
  output logic                sclk_o,
  output logic                syncn_o,
  output logic                ldacn_o,
  output logic [NumCh-1:0]    sdo_o
);

  dac_state_e state_q, state_d;

  logic [NumCh-1:0][DacWidth-1:0] shreg_q, shreg_d;
  logic [BitCntW-1:0]             bit_cnt_q, bit_cnt_d;
  // 0: SCLK-high half of the current bit, 1: SCLK-low half.
  logic                           half_q, half_d;
  logic                           ovf_q, ovf_d;
  logic                           accept;
  logic                           tick;
  logic                           bit_done;

  assign accept   = valid_i && (state_q == StIdle);
  assign bit_done = tick && half_q;

  ocra1_sclk_div #(
    .SCLK_DIV (SCLK_DIV)
  ) u_sclk_div (
    .clk       (clk),
    .rst       (rst),
    .restart_i (accept),
    .en_i      (state_q != StIdle),
    .tick_o    (tick)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; every non-idle state advances on a divider tick.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StShift;
      StShift: if (bit_done && (bit_cnt_q == '0)) state_d = StGap;
      StGap:   if (tick) state_d = (LDAC_EN != 0) ? StLdac : StIdle;
      StLdac:  if (tick) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state so they move one cycle after accept.
  always_comb begin
    busy_o     = (state_q != StIdle);
    syncn_o    = (state_q != StShift);
    ldacn_o    = (state_q != StLdac);
    sclk_o     = !((state_q == StShift) && half_q);
    overflow_o = ovf_q;
    for (int ch = 0; ch < NumCh; ch++) begin
      sdo_o[ch] = (state_q == StShift) ? shreg_q[ch][DacWidth-1] : 1'b0;
    end
  end

  // Shift datapath: load on accept, advance one bit at the end of each SCLK-low half.
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    half_d    = half_q;
    if (accept) begin
      shreg_d[0] = dac0_i;
      shreg_d[1] = dac1_i;
      shreg_d[2] = dac2_i;
      shreg_d[3] = dac3_i;
      bit_cnt_d  = BitCntW'(DacWidth - 1);
      half_d     = 1'b0;
    end else if ((state_q == StShift) && tick) begin
      if (!half_q) begin
        half_d = 1'b1;
      end else begin
        half_d = 1'b0;
        // Bit 0 is final: counter holds rather than wrapping.
        if (bit_cnt_q != '0) begin
          bit_cnt_d = bit_cnt_q - BitCntW'(1);
          for (int ch = 0; ch < NumCh; ch++) begin
            shreg_d[ch] = {shreg_q[ch][DacWidth-2:0], 1'b0};
          end
        end
      end
    end
  end

  // Sticky overflow: a strobe while busy sets it and beats a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if (valid_i && (state_q != StIdle)) begin
      ovf_d = 1'b1;
    end else if (clear_i) begin
      ovf_d = 1'b0;
    end
  end

  // Datapath and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      half_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      half_q    <= half_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule
